// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign busy = (state != IDLE);

  // Signed ops work on magnitudes; the sign flags restore the result in SIGN.
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;
  end

  // acc holds {partial product, multiplier} or {remainder, quotient/dividend}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divide by zero yields all-ones quotient; the remainder is then the original dividend.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = rem_fix;
      res_lo = (opnd == '0) ? {WIDTH{1'b1}} : quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            opnd   <= op[1] ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt    <= '0;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= SIGN;
        end
        SIGN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
